// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared mode type, counter width and reference model for the approximate multiplier
package approx_mult_pkg;

    localparam int CNT_W = 16;

    typedef enum logic {
        MODE_EXACT  = 1'b0,
        MODE_APPROX = 1'b1
    } mode_e;

    // Bit-level model of the approximate product; supports w up to 32.
    function automatic logic [63:0] approx_ref(input logic [31:0] x, input logic [31:0] y,
                                               input int w, input int l, input int or_win);
        logic [63:0] acc;
        logic [63:0] ymask;
        logic        bit_a;
        logic        bit_b;
        logic        s;
        logic        cy;
        ymask = (64'd1 << w) - 64'd1;
        acc   = '0;
        for (int i = w - 2; i < w; i++) begin
            if (x[5'(i)]) acc = acc + (({32'd0, y} & ymask) << i);
        end
        for (int k = 0; k <= w / 2 - 2; k++) begin
            for (int c = l; c < 2 * w; c++) begin
                bit_a = (c >= 2 * k && c - 2 * k < w) ? (x[5'(2 * k)] & y[5'(c - 2 * k)]) : 1'b0;
                bit_b = (c >= 2 * k + 1 && c - 2 * k - 1 < w) ? (x[5'(2 * k + 1)] & y[5'(c - 2 * k - 1)]) : 1'b0;
                s     = (c < l + or_win) ? (bit_a | bit_b) : (bit_a ^ bit_b);
                cy    = bit_a & bit_b;
                acc   = acc + ({63'd0, s} << c) + ({63'd0, cy} << (c + 1));
            end
        end
        if (2 * w < 64) acc = acc & ((64'd1 << (2 * w)) - 64'd1);
        return acc;
    endfunction

endpackage

// File: rtl/approx_pp_compress.sv
// rtl/approx_pp_compress.sv - combinational row-pair compressor between partial products and the final add
module approx_pp_compress
    import approx_mult_pkg::*;
#(
    parameter int W      = 8,
    parameter int L      = 6,
    parameter int OR_WIN = 2
) (
    input  logic [W-1:0][W-1:0]       i_pp,
    input  mode_e                     i_mode,
    output logic [W/2-2:0][2*W-1:0]   o_sum,
    output logic [W/2-2:0][2*W-1:0]   o_cy,
    output logic [2*W-1:0]            o_base
);

    localparam int PW = 2 * W;
    localparam int NP = W / 2 - 1;

    logic w_approx;

    assign w_approx = (i_mode == MODE_APPROX);

    // The two top rows carry most of the product weight and are always kept exact.
    assign o_base = (PW'(i_pp[W-2]) << (W - 2)) + (PW'(i_pp[W-1]) << (W - 1));

    for (genvar k = 0; k < NP; k++) begin : g_pair
        assign o_cy[k][0] = 1'b0;
        for (genvar c = 0; c < PW; c++) begin : g_col
            localparam int RA       = 2 * k;
            localparam int RB       = 2 * k + 1;
            localparam bit IS_TRUNC = (c < L);
            localparam bit IS_OR    = (c < L + OR_WIN);
            logic w_a;
            logic w_b;
            logic w_kill;
            if (c >= RA && c - RA < W) begin : g_a
                assign w_a = i_pp[RA][c-RA];
            end else begin : g_a0
                assign w_a = 1'b0;
            end
            if (c >= RB && c - RB < W) begin : g_b
                assign w_b = i_pp[RB][c-RB];
            end else begin : g_b0
                assign w_b = 1'b0;
            end
            assign w_kill      = w_approx & IS_TRUNC;
            assign o_sum[k][c] = !w_kill & ((w_approx & IS_OR) ? (w_a | w_b) : (w_a ^ w_b));
            // Carry out of the top column falls outside the 2W-bit result.
            if (c + 1 < PW) begin : g_cy
                assign o_cy[k][c+1] = !w_kill & w_a & w_b;
            end
        end
    end

endmodule

// File: rtl/approx_trunc_mult_pipe.sv
// rtl/approx_trunc_mult_pipe.sv - three-stage exact/approximate WxW multiplier with valid/ready handshake
module approx_trunc_mult_pipe
    import approx_mult_pkg::*;
#(
    parameter int W      = 8,
    parameter int L      = 6,
    parameter int OR_WIN = 2,
    parameter int TAG_W  = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    input  logic [W-1:0]     in_y,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_z,
    output logic [TAG_W-1:0] out_tag,
    output logic [CNT_W-1:0] approx_cnt
);

    localparam int PW = 2 * W;
    localparam int NP = W / 2 - 1;

    logic                  w_adv;
    logic [W-1:0][W-1:0]   w_pp;
    logic [NP-1:0][PW-1:0] w_s2_sum;
    logic [NP-1:0][PW-1:0] w_s2_cy;
    logic [PW-1:0]         w_s2_base;
    logic [PW-1:0]         w_s3_z;

    logic                  r_s1_valid;
    mode_e                 r_s1_mode;
    logic [TAG_W-1:0]      r_s1_tag;
    logic [W-1:0][W-1:0]   r_s1_pp;
    logic [W-1:0]          r_s1_x;
    logic [W-1:0]          r_s1_y;

    logic                  r_s2_valid;
    mode_e                 r_s2_mode;
    logic [TAG_W-1:0]      r_s2_tag;
    logic [NP-1:0][PW-1:0] r_s2_sum;
    logic [NP-1:0][PW-1:0] r_s2_cy;
    logic [PW-1:0]         r_s2_base;
    logic [W-1:0]          r_s2_x;
    logic [W-1:0]          r_s2_y;

    logic                  r_out_valid;
    mode_e                 r_out_mode;
    logic [PW-1:0]         r_out_z;
    logic [TAG_W-1:0]      r_out_tag;
    logic [CNT_W-1:0]      r_cnt;

    // One stall signal for the whole pipe: bubbles are kept, never squeezed out.
    assign w_adv     = !r_out_valid | out_ready;
    assign in_ready  = w_adv;
    assign out_valid = r_out_valid;
    assign out_z     = r_out_z;
    assign out_tag   = r_out_tag;
    assign approx_cnt = r_cnt;

    for (genvar i = 0; i < W; i++) begin : g_pp
        assign w_pp[i] = in_y & {W{in_x[i]}};
    end

    approx_pp_compress #(
        .W      (W),
        .L      (L),
        .OR_WIN (OR_WIN)
    ) u_compress (
        .i_pp   (r_s1_pp),
        .i_mode (r_s1_mode),
        .o_sum  (w_s2_sum),
        .o_cy   (w_s2_cy),
        .o_base (w_s2_base)
    );

    for (genvar k = 0; k < NP; k++) begin : g_add
        logic [PW-1:0] w_part;
        if (k == 0) begin : g_first
            assign w_part = r_s2_base + r_s2_sum[k] + r_s2_cy[k];
        end else begin : g_next
            assign w_part = g_add[k-1].w_part + r_s2_sum[k] + r_s2_cy[k];
        end
    end
    assign w_s3_z = g_add[NP-1].w_part;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid  <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_mode  <= MODE_EXACT;
            r_out_z     <= '0;
            r_out_tag   <= '0;
            r_cnt       <= '0;
        end else begin
            if (w_adv) begin
                r_s1_valid  <= in_valid;
                r_s2_valid  <= r_s1_valid;
                r_out_valid <= r_s2_valid;
                if (r_s2_valid) begin
                    r_out_z    <= w_s3_z;
                    r_out_tag  <= r_s2_tag;
                    r_out_mode <= r_s2_mode;
                end
            end
            if (r_out_valid && out_ready && r_out_mode == MODE_APPROX && r_cnt != '1) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Stage payloads need no reset: they are qualified by the stage valids.
    always_ff @(posedge clk) begin
        if (w_adv && in_valid) begin
            r_s1_pp   <= w_pp;
            r_s1_mode <= mode_e'(in_mode);
            r_s1_tag  <= in_tag;
            r_s1_x    <= in_x;
            r_s1_y    <= in_y;
        end
        if (w_adv && r_s1_valid) begin
            r_s2_sum  <= w_s2_sum;
            r_s2_cy   <= w_s2_cy;
            r_s2_base <= w_s2_base;
            r_s2_mode <= r_s1_mode;
            r_s2_tag  <= r_s1_tag;
            r_s2_x    <= r_s1_x;
            r_s2_y    <= r_s1_y;
        end
    end

    always @(posedge clk) begin
        if (!rst && w_adv && r_s2_valid) begin
            assert (64'(w_s3_z) == ((r_s2_mode == MODE_APPROX)
                    ? approx_ref(32'(r_s2_x), 32'(r_s2_y), W, L, OR_WIN)
                    : 64'(r_s2_x) * 64'(r_s2_y)));
        end
    end

endmodule

// File: tb/tb_approx_trunc_mult_pipe.sv
// tb/tb_approx_trunc_mult_pipe.sv - self-checking bench for approx_trunc_mult_pipe
module tb_approx_trunc_mult_pipe;
    import approx_mult_pkg::*;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic        m;
        logic [15:0] z;
    } vec_t;

    typedef struct {
        logic [15:0] z;
        logic [15:0] z0;
        logic [3:0]  tag;
        logic        m;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_x;
    logic [7:0]  in_y;
    logic        in_mode;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_z;
    logic [3:0]  out_tag;
    logic [15:0] approx_cnt;

    logic        in_ready0;
    logic        out_valid0;
    logic [15:0] out_z0;
    logic [3:0]  out_tag0;
    logic [15:0] approx_cnt0;

    int          n_chk;
    int          n_fail;
    int          n_pop;
    int          b;
    int          pop_mark;
    logic [15:0] exp_cnt;
    logic        stall_prev;
    logic [15:0] prev_z;
    logic [3:0]  prev_tag;
    logic [7:0]  rx;
    logic [7:0]  ry;
    logic        rm;
    exp_t        cur;
    exp_t        e;
    exp_t        sb[$];
    vec_t        vecs[10];

    approx_trunc_mult_pipe #(.W(8), .L(6), .OR_WIN(2), .TAG_W(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_z      (out_z),
        .out_tag    (out_tag),
        .approx_cnt (approx_cnt)
    );

    approx_trunc_mult_pipe #(.W(8), .L(0), .OR_WIN(0), .TAG_W(4)) dut_ref (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready0),
        .in_x       (in_x),
        .in_y       (in_y),
        .in_mode    (in_mode),
        .in_tag     (in_tag),
        .out_valid  (out_valid0),
        .out_ready  (out_ready),
        .out_z      (out_z0),
        .out_tag    (out_tag0),
        .approx_cnt (approx_cnt0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [7:0] x, input logic [7:0] y, input logic m);
        logic [63:0] r;
        if (m) r = approx_ref({24'd0, x}, {24'd0, y}, 8, 6, 2);
        else   r = 64'(x) * 64'(y);
        return r[15:0];
    endfunction

    task automatic drive(input logic v, input logic [7:0] x, input logic [7:0] y,
                         input logic m, input logic [3:0] t, input logic [15:0] z);
        in_valid = v;
        in_x     = x;
        in_y     = y;
        in_mode  = m;
        in_tag   = t;
        cur.z    = z;
        cur.z0   = 16'(x) * 16'(y);
        cur.tag  = t;
        cur.m    = m;
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((sb.size() != 0 || out_valid) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk(name, 64'(n < 50), 64'd1);
    endtask

    // Scoreboard: handshakes are decided at the next rising edge, so sample at the falling edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                sb.delete();
                exp_cnt    = '0;
                stall_prev = 1'b0;
            end else begin
                chk("approx_cnt", 64'(approx_cnt), 64'(exp_cnt));
                if (stall_prev) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_z", 64'(out_z), 64'(prev_z));
                    chk("stall_tag", 64'(out_tag), 64'(prev_tag));
                end
                if (out_valid && out_ready) begin
                    chk("sb_not_empty", 64'(sb.size() != 0), 64'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("out_z", 64'(out_z), 64'(e.z));
                        chk("out_tag", 64'(out_tag), 64'(e.tag));
                        chk("ref_valid", 64'(out_valid0), 64'd1);
                        chk("ref_exact_z", 64'(out_z0), 64'(e.z0));
                        if (e.m && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                    end
                    n_pop++;
                end
                stall_prev = out_valid && !out_ready;
                prev_z     = out_z;
                prev_tag   = out_tag;
                if (in_valid && in_ready) sb.push_back(cur);
            end
        end
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hFF, 8'hFF, 1'b0, 16'd65025};
        vecs[1] = '{8'hC0, 8'hFF, 1'b1, 16'd48960};
        vecs[2] = '{8'h00, 8'hAB, 1'b1, 16'd0};
        vecs[3] = '{8'hFF, 8'h00, 1'b1, 16'd0};
        vecs[4] = '{8'h03, 8'hFF, 1'b1, 16'd832};
        vecs[5] = '{8'h03, 8'hFF, 1'b0, 16'd765};
        vecs[6] = '{8'h0C, 8'hFF, 1'b1, 16'd3136};
        vecs[7] = '{8'h01, 8'h01, 1'b1, 16'd0};
        vecs[8] = '{8'h80, 8'h80, 1'b1, 16'd16384};
        vecs[9] = '{8'hA5, 8'h3C, 1'b0, 16'd9900};

        n_chk     = 0;
        n_fail    = 0;
        n_pop     = 0;
        exp_cnt   = '0;
        rst       = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_z", 64'(out_z), 64'd0);
        chk("rst_out_tag", 64'(out_tag), 64'd0);
        chk("rst_approx_cnt", 64'(approx_cnt), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        rst = 1'b0;

        // Exact 255*255 with three-cycle latency.
        @(posedge clk); #1;
        drive(1'b1, 8'hFF, 8'hFF, 1'b0, 4'd1, 16'd65025);
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        @(negedge clk);
        chk("lat_cycle1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle2", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("lat_cycle3", 64'(out_valid), 64'd1);
        chk("lat_z", 64'(out_z), 64'd65025);
        chk("exact_cnt", 64'(approx_cnt), 64'd0);

        // Approximate top-rows-only product bumps the counter once.
        @(posedge clk); #1;
        drive(1'b1, 8'hC0, 8'hFF, 1'b1, 4'd2, 16'd48960);
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        repeat (5) @(negedge clk);
        chk("approx_cnt_one", 64'(approx_cnt), 64'd1);

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            drive(1'b1, vecs[i].x, vecs[i].y, vecs[i].m, 4'(i), vecs[i].z);
        end
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        wait_drain("drain_table");

        // Back-to-back stream with downstream stalled for three cycles.
        pop_mark = n_pop;
        b = 0;
        for (int cyc = 0; cyc < 40 && b < 8; cyc++) begin
            @(posedge clk); #1;
            out_ready = !(cyc >= 4 && cyc <= 6);
            rx = 8'($urandom);
            ry = 8'($urandom);
            rm = 1'($urandom);
            drive(1'b1, rx, ry, rm, 4'(b), model(rx, ry, rm));
            @(negedge clk);
            if (in_valid && in_ready) b++;
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        chk("stream_sent", 64'(b), 64'd8);
        wait_drain("drain_stream");
        chk("stream_delivered", 64'(n_pop - pop_mark), 64'd8);

        // Reset with three beats in flight.
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            drive(1'b1, 8'h5A, 8'h33, 1'b1, 4'(9 + i), model(8'h5A, 8'h33, 1'b1));
        end
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        rst = 1'b1;
        pop_mark = n_pop;
        @(negedge clk);
        chk("rst_flush_valid", 64'(out_valid), 64'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (10) @(negedge clk);
        chk("rst_no_stale", 64'(n_pop - pop_mark), 64'd0);
        chk("rst_cnt_cleared", 64'(approx_cnt), 64'd0);

        // Random mixed traffic with random backpressure.
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk); #1;
            out_ready = ($urandom_range(0, 9) < 7);
            rx = 8'($urandom);
            ry = 8'($urandom);
            rm = 1'($urandom);
            drive(1'($urandom_range(0, 9) < 7), rx, ry, rm, 4'(i), model(rx, ry, rm));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        wait_drain("drain_random");

        // Counter saturation.
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 65540; i++) begin
            @(posedge clk); #1;
            rx = 8'($urandom);
            ry = 8'($urandom);
            drive(1'b1, rx, ry, 1'b1, 4'(i), model(rx, ry, 1'b1));
        end
        @(posedge clk); #1;
        drive(1'b0, 8'd0, 8'd0, 1'b0, 4'd0, 16'd0);
        wait_drain("drain_sat");
        chk("cnt_saturated", 64'(approx_cnt), 64'd65535);
        chk("ref_cnt_saturated", 64'(approx_cnt0), 64'd65535);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
